sad_accum_intra: RTL and testbench

// Streaming SAD accumulator and best-mode selector for intra prediction. Takes

---
 rtl/sad_accum_intra.sv | 138 +++++++++++++
 tb/tb_sad_accum_intra.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum_intra.sv
// sad_accum_intra: per-mode SAD accumulation over one block, then a sequential minimum scan
module sad_accum_intra #(
    parameter int NUM_MODES = 3,
    parameter int BLK_W = 8,
    parameter int BLK_H = 8,
    parameter int LANES = 8,
    parameter int SAMP_W = 9,
    localparam int BEATS = BLK_W * BLK_H / LANES,
    localparam int SAD_W = SAMP_W + $clog2(BLK_W * BLK_H),
    localparam int IDX_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [NUM_MODES*LANES*SAMP_W-1:0]   in_res_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [NUM_MODES*SAD_W-1:0]          sads_o,
    output logic [IDX_W-1:0]                    best_mode_o,
    output logic [SAD_W-1:0]                    best_sad_o,
    output logic                                busy_o
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, OUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [SAD_W-1:0] acc_q [NUM_MODES];
    logic [SAD_W-1:0] acc_d [NUM_MODES];
    logic [SAD_W-1:0] sads_q [NUM_MODES];
    logic [SAD_W-1:0] sads_d [NUM_MODES];
    logic [SAD_W-1:0] beat_sum [NUM_MODES];
    logic [IDX_W-1:0] best_mode_q, best_mode_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic             last_beat, last_mode, take;

    // Magnitude taken one bit wider so the most negative sample has an exact positive value
    function automatic logic [SAD_W-1:0] mag(input logic [SAMP_W-1:0] s);
        logic [SAMP_W:0] e;
        logic [SAMP_W:0] a;
        e = {s[SAMP_W-1], s};
        a = e[SAMP_W] ? -e : e;
        return SAD_W'(a);
    endfunction

    // Sum of lane magnitudes per mode for the beat currently presented
    always_comb begin
        for (int m = 0; m < NUM_MODES; m++) begin
            beat_sum[m] = '0;
            for (int l = 0; l < LANES; l++)
                beat_sum[m] = beat_sum[m] + mag(in_res_i[(m*LANES+l)*SAMP_W +: SAMP_W]);
        end
    end

    assign last_beat = beat_q == CNT_W'(BEATS - 1);
    assign last_mode = k_q == IDX_W'(NUM_MODES - 1);
    assign take      = (k_q == '0) || (sads_q[k_q] < best_sad_q);

    // Next-state logic: block accumulation, one-mode-per-cycle minimum scan, result handshake
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        k_d         = k_q;
        acc_d       = acc_q;
        sads_d      = sads_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    for (int m = 0; m < NUM_MODES; m++)
                        acc_d[m] = '0;
                    beat_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid_i) begin
                    for (int m = 0; m < NUM_MODES; m++)
                        acc_d[m] = acc_q[m] + beat_sum[m];
                    beat_d = last_beat ? '0 : beat_q + CNT_W'(1);
                    if (last_beat) begin
                        sads_d  = acc_d;
                        k_d     = '0;
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                best_mode_d = take ? k_q : best_mode_q;
                best_sad_d  = take ? sads_q[k_q] : best_sad_q;
                k_d         = last_mode ? '0 : k_q + IDX_W'(1);
                state_d     = last_mode ? OUT : COMPARE;
            end
            OUT: begin
                state_d = out_ready_i ? IDLE : OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial block
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            k_q         <= '0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            for (int m = 0; m < NUM_MODES; m++) begin
                acc_q[m]  <= '0;
                sads_q[m] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            k_q         <= k_d;
            best_mode_q <= best_mode_d;
            best_sad_q  <= best_sad_d;
            acc_q       <= acc_d;
            sads_q      <= sads_d;
        end
    end

    assign in_ready_o  = state_q == ACCUM;
    assign out_valid_o = state_q == OUT;
    assign busy_o      = state_q != IDLE;
    assign best_mode_o = best_mode_q;
    assign best_sad_o  = best_sad_q;

    for (genvar g = 0; g < NUM_MODES; g++) begin : g_sads
        assign sads_o[g*SAD_W +: SAD_W] = sads_q[g];
    end
endmodule

// File: tb/tb_sad_accum_intra.sv
// tb_sad_accum_intra: directed blocks checked against a whole-block SAD/argmin model
module tb_sad_accum_intra;
    localparam int NM     = 3;
    localparam int LANES  = 8;
    localparam int SAMP_W = 9;
    localparam int BEATS  = 8;
    localparam int SAD_W  = 15;
    localparam int IDX_W  = 2;
    localparam int NS     = BEATS * LANES;

    logic                      clk_i = 1'b0;
    logic                      reset_i = 1'b1;
    logic                      start_i = 1'b0;
    logic                      in_valid_i = 1'b0;
    logic                      out_ready_i = 1'b0;
    logic [NM*LANES*SAMP_W-1:0] in_res_i = '0;
    logic                      in_ready_o;
    logic                      out_valid_o;
    logic                      busy_o;
    logic [NM*SAD_W-1:0]       sads_o;
    logic [IDX_W-1:0]          best_mode_o;
    logic [SAD_W-1:0]          best_sad_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    bit armed = 1'b0;
    bit prev_ov = 1'b0;
    int exp_sad [NM];
    int exp_best = 0;
    int exp_best_sad = 0;

    sad_accum_intra dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .start_i(start_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_res_i(in_res_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .sads_o(sads_o),
        .best_mode_o(best_mode_o),
        .best_sad_o(best_sad_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Residual for pattern pat, mode m, sample index i within the block
    function automatic int val(input int pat, input int m, input int i);
        case (pat)
            1: return m == 0 ? 0 : (m == 1 ? 1 : -3);
            2: return m == 0 ? -256 : (m == 1 ? 255 : ((i % 2 == 0) ? 2 : -2));
            3: return m == 0 ? (i == 0 ? -41 : 0) : (m == 1 ? (i < 8 ? 5 : 0) : (i < 4 ? -10 : 0));
            default: return 1;
        endcase
    endfunction

    // Whole-block expectation: total |residual| per mode, first index of the minimum
    task automatic model(input int pat);
        for (int m = 0; m < NM; m++) begin
            int s;
            s = 0;
            for (int i = 0; i < NS; i++) begin
                int v;
                v = val(pat, m, i);
                s += (v < 0) ? -v : v;
            end
            exp_sad[m] = s;
        end
        exp_best = 0;
        exp_best_sad = exp_sad[0];
        for (int m = 1; m < NM; m++)
            if (exp_sad[m] < exp_best_sad) begin
                exp_best = m;
                exp_best_sad = exp_sad[m];
            end
        armed = 1'b1;
    endtask

    function automatic logic [NM*LANES*SAMP_W-1:0] beat(input int pat, input int b);
        logic [NM*LANES*SAMP_W-1:0] v;
        v = '0;
        for (int m = 0; m < NM; m++)
            for (int l = 0; l < LANES; l++)
                v[(m*LANES+l)*SAMP_W +: SAMP_W] = SAMP_W'(val(pat, m, b*LANES+l));
        return v;
    endfunction

    // Output checker: every cycle results are presented they must match the model
    always @(negedge clk_i) begin
        if (reset_i) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid_o) begin
                if (!armed) begin
                    chk("unexpected_out_valid", out_valid_o, 0);
                end else begin
                    if (!prev_ov)
                        chk("latency", cyc - last_acc, NM);
                    for (int m = 0; m < NM; m++)
                        chk($sformatf("sads[%0d]", m), sads_o[m*SAD_W +: SAD_W], exp_sad[m]);
                    chk("best_mode", best_mode_o, exp_best);
                    chk("best_sad", best_sad_o, exp_best_sad);
                    chk("busy_in_out", busy_o, 1);
                    chk("in_ready_in_out", in_ready_o, 0);
                end
            end
            prev_ov = out_valid_o;
        end
    end

    task automatic start_block(input int pat);
        model(pat);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic feed(input int pat, input int gap, input int nb);
        int b;
        int t;
        bit acc;
        b = 0;
        t = 0;
        while (b < nb) begin
            if (t > 200) begin
                chk("feed_timeout", b, nb);
                break;
            end
            in_valid_i = ((t % (gap + 1)) == 0);
            in_res_i = in_valid_i ? beat(pat, b) : ~beat(pat, b);
            acc = in_valid_i && in_ready_o;
            if (acc) last_acc = cyc + 1;
            @(negedge clk_i);
            t++;
            if (acc) b++;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic finish_block(input int hold);
        int t;
        t = 0;
        while (!out_valid_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        if (!out_valid_o) chk("out_valid_timeout", out_valid_o, 1);
        for (int i = 0; i < hold; i++) begin
            start_i = (i == 2);
            @(negedge clk_i);
        end
        if (hold > 0) chk("held_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        start_i = (hold > 0);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        start_i = 1'b0;
        armed = 1'b0;
    endtask

    task automatic lit(input string tag, input int s0, input int s1, input int s2, input int bm, input int bs);
        chk({tag, "_sad0"}, sads_o[0*SAD_W +: SAD_W], s0);
        chk({tag, "_sad1"}, sads_o[1*SAD_W +: SAD_W], s1);
        chk({tag, "_sad2"}, sads_o[2*SAD_W +: SAD_W], s2);
        chk({tag, "_best_mode"}, best_mode_o, bm);
        chk({tag, "_best_sad"}, best_sad_o, bs);
    endtask

    initial begin
        #3;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sads", sads_o, 0);
        chk("rst_best_mode", best_mode_o, 0);
        chk("rst_best_sad", best_sad_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        start_block(1);
        feed(1, 0, BEATS);
        finish_block(0);
        lit("blk1", 0, 64, 192, 0, 0);

        start_block(2);
        feed(2, 2, BEATS);
        finish_block(5);
        lit("blk2", 16384, 16320, 128, 2, 128);
        for (int i = 0; i < 3; i++) begin
            chk("idle_busy", busy_o, 0);
            chk("idle_in_ready", in_ready_o, 0);
            @(negedge clk_i);
        end

        start_block(1);
        feed(1, 0, 4);
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready_o, 0);
        chk("midrst_out_valid", out_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_sads", sads_o, 0);
        chk("midrst_best_sad", best_sad_o, 0);
        armed = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        start_block(4);
        feed(4, 0, BEATS);
        finish_block(0);
        lit("blk4", 64, 64, 64, 0, 64);

        start_block(2);
        feed(2, 0, BEATS);
        finish_block(0);
        lit("b2b_first", 16384, 16320, 128, 2, 128);
        start_block(3);
        feed(3, 0, BEATS);
        finish_block(0);
        lit("b2b_second", 41, 40, 40, 1, 40);

        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
